simon_game_ctrl: RTL and testbench

Parametrised Simon game controller, successor to the fixed four-button top-level FSM. It owns the round sequencing between the debounced buttons, the PRNG, the tone generator and the LED driver. It stores the generated colour sequence internally, so replay no longer depends on re-running the PRNG. It adds an input timeout, multi-press rejection, a win condition at maximum length and optional tempo speed-up.

---
 rtl/simon_pkg.sv | 39 +++
 rtl/simon_seq_mem.sv | 24 ++
 rtl/simon_game_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_simon_game_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types, width helpers and default timing for the Simon game controller.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXTEND,
    ST_PLAY_ON,
    ST_PLAY_OFF,
    ST_WAIT_IN,
    ST_WAIT_REL,
    ST_LOSE,
    ST_WIN
  } state_t;

  localparam int unsigned DEF_N_BTN          = 4;
  localparam int unsigned DEF_MAX_LEN        = 32;
  localparam int unsigned DEF_TONE_CYCLES    = 37_500_000;
  localparam int unsigned DEF_GAP_CYCLES     = 12_500_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 250_000_000;
  localparam int unsigned DEF_END_CYCLES     = 100_000_000;

  function automatic int unsigned cw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned lw_of(input int unsigned m);
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned tw_of(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
    return cw_of(max_of(max_of(a, b), max_of(c, d)));
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence store: one synchronous write port, one asynchronous read port.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_LEN,
  parameter int unsigned WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [cw_of(DEPTH)-1:0]    i_waddr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic [cw_of(DEPTH)-1:0]    i_raddr,
  output logic [WIDTH-1:0]           o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon round sequencer: extends, replays and checks a stored colour sequence.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned N_BTN          = DEF_N_BTN,
  parameter int unsigned MAX_LEN        = DEF_MAX_LEN,
  parameter int unsigned TONE_CYCLES    = DEF_TONE_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned END_CYCLES     = DEF_END_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        speedup,
  input  logic [N_BTN-1:0]            btn_held,
  input  logic [cw_of(N_BTN)-1:0]     rand_val,
  output logic                        rand_step,
  output logic [cw_of(N_BTN)-1:0]     color,
  output logic                        color_en,
  output logic                        lose_tone,
  output logic                        win_flag,
  output logic [lw_of(MAX_LEN)-1:0]   score,
  output logic                        busy
);

  localparam int unsigned CW = cw_of(N_BTN);
  localparam int unsigned LW = lw_of(MAX_LEN);
  localparam int unsigned AW = cw_of(MAX_LEN);
  localparam int unsigned TW = tw_of(TONE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES, END_CYCLES);

  localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] END_LAST     = TW'(END_CYCLES - 1);
  localparam logic [LW-1:0] MAX_LEN_L    = LW'(MAX_LEN);

  state_t          r_state, w_nxt_state;
  logic [TW-1:0]   r_timer, w_tone_last;
  logic [LW-1:0]   r_score, r_len, r_idx;
  logic [LW-1:0]   w_nxt_score, w_nxt_len, w_nxt_idx, w_idx_inc;
  logic [CW-1:0]   r_pressed, w_nxt_pressed, w_btn_code, w_rdata, w_play_color;
  logic [1:0]      r_shift, w_sel_shift;
  logic [AW-1:0]   w_raddr;
  logic [N_BTN-1:0] w_press_mask;
  logic            w_more, w_one, w_none, w_extra, w_we;
  logic            r_rand_step, r_color_en, r_lose_tone, r_win_flag, r_busy;
  logic [CW-1:0]   r_color;

  assign w_idx_inc    = r_idx + 1'b1;
  assign w_more       = (w_idx_inc < r_len);
  assign w_one        = $onehot(btn_held);
  assign w_none       = (btn_held == '0);
  assign w_press_mask = N_BTN'(1) << r_pressed;
  assign w_extra      = |(btn_held & ~w_press_mask);
  assign w_tone_last  = TW'((TONE_CYCLES >> r_shift) - 1);
  assign w_we         = (r_state == ST_EXTEND);

  always_comb begin
    w_btn_code = '0;
    for (int unsigned i = 0; i < N_BTN; i++)
      if (btn_held[i]) w_btn_code = CW'(i);
  end

  always_comb begin
    w_sel_shift = 2'd0;
    if (speedup) begin
      if (32'(r_score) >= 32'd16)     w_sel_shift = 2'd2;
      else if (32'(r_score) >= 32'd8) w_sel_shift = 2'd1;
    end
  end

  // Read address tracks the entry the outputs need on the next edge.
  always_comb begin
    w_raddr = AW'(r_idx);
    if (r_state == ST_EXTEND)                  w_raddr = '0;
    else if (r_state == ST_PLAY_OFF && w_more) w_raddr = AW'(w_idx_inc);
  end

  simon_seq_mem #(
    .DEPTH (MAX_LEN),
    .WIDTH (CW)
  ) u_seq_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (AW'(r_len)),
    .i_wdata (rand_val),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // First round: seq[0] is written on the same edge it is first shown.
  assign w_play_color = (r_state == ST_EXTEND && r_len == '0) ? rand_val : w_rdata;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_score   = r_score;
    w_nxt_len     = r_len;
    w_nxt_idx     = r_idx;
    w_nxt_pressed = r_pressed;
    case (r_state)
      ST_IDLE: if (start) begin
        w_nxt_score = '0;
        w_nxt_len   = '0;
        w_nxt_idx   = '0;
        w_nxt_state = ST_EXTEND;
      end
      ST_EXTEND: begin
        w_nxt_len   = r_len + 1'b1;
        w_nxt_idx   = '0;
        w_nxt_state = ST_PLAY_ON;
      end
      ST_PLAY_ON: if (r_timer == w_tone_last) w_nxt_state = ST_PLAY_OFF;
      ST_PLAY_OFF: if (r_timer == GAP_LAST) begin
        if (w_more) begin
          w_nxt_idx   = w_idx_inc;
          w_nxt_state = ST_PLAY_ON;
        end else begin
          w_nxt_idx   = '0;
          w_nxt_state = ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (w_one) begin
          w_nxt_pressed = w_btn_code;
          w_nxt_state   = ST_WAIT_REL;
        end else if (!w_none || r_timer == TIMEOUT_LAST) begin
          w_nxt_state = ST_LOSE;
        end
      end
      ST_WAIT_REL: begin
        if (w_extra) w_nxt_state = ST_LOSE;
        else if (w_none) begin
          if (r_pressed != w_rdata) w_nxt_state = ST_LOSE;
          else if (w_more) begin
            w_nxt_idx   = w_idx_inc;
            w_nxt_state = ST_WAIT_IN;
          end else begin
            w_nxt_score = r_score + 1'b1;
            w_nxt_state = (w_nxt_score == MAX_LEN_L) ? ST_WIN : ST_EXTEND;
          end
        end
      end
      ST_LOSE: if (r_timer == END_LAST) w_nxt_state = ST_IDLE;
      ST_WIN:  if (r_timer == END_LAST) w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_score     <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_pressed   <= '0;
      r_shift     <= '0;
      r_rand_step <= 1'b0;
      r_color     <= '0;
      r_color_en  <= 1'b0;
      r_lose_tone <= 1'b0;
      r_win_flag  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_timer   <= (w_nxt_state != r_state) ? '0 : r_timer + 1'b1;
      r_score   <= w_nxt_score;
      r_len     <= w_nxt_len;
      r_idx     <= w_nxt_idx;
      r_pressed <= w_nxt_pressed;
      if (w_nxt_state == ST_PLAY_ON && r_state != ST_PLAY_ON) r_shift <= w_sel_shift;
      r_rand_step <= (w_nxt_state == ST_EXTEND);
      r_color_en  <= (w_nxt_state == ST_PLAY_ON) || (w_nxt_state == ST_WAIT_REL);
      r_color     <= (w_nxt_state == ST_PLAY_ON)  ? w_play_color :
                     (w_nxt_state == ST_WAIT_REL) ? w_nxt_pressed : '0;
      r_lose_tone <= (w_nxt_state == ST_LOSE);
      r_win_flag  <= (w_nxt_state == ST_WIN);
      r_busy      <= (w_nxt_state != ST_IDLE);
    end
  end

  assign rand_step = r_rand_step;
  assign color     = r_color;
  assign color_en  = r_color_en;
  assign lose_tone = r_lose_tone;
  assign win_flag  = r_win_flag;
  assign score     = r_score;
  assign busy      = r_busy;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl: a MAX_LEN=16 unit plus a MAX_LEN=3 unit for the win path.
module tb_simon_game_ctrl;

  localparam int unsigned TONE = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned TMO  = 20;
  localparam int unsigned ENDC = 5;

  logic       clk = 1'b0;
  logic       reset, start, speedup;
  logic [3:0] btn_held;
  logic [1:0] rand_val;

  logic       a_rand_step, a_color_en, a_lose_tone, a_win_flag, a_busy;
  logic [1:0] a_color;
  logic [4:0] a_score;
  logic       b_rand_step, b_color_en, b_lose_tone, b_win_flag, b_busy;
  logic [1:0] b_color;
  logic [1:0] b_score;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_seq [16];

  always #5 clk = ~clk;

  simon_game_ctrl #(
    .N_BTN(4), .MAX_LEN(16), .TONE_CYCLES(TONE), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO), .END_CYCLES(ENDC)
  ) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .speedup(speedup),
    .btn_held(btn_held), .rand_val(rand_val), .rand_step(a_rand_step),
    .color(a_color), .color_en(a_color_en), .lose_tone(a_lose_tone),
    .win_flag(a_win_flag), .score(a_score), .busy(a_busy)
  );

  simon_game_ctrl #(
    .N_BTN(4), .MAX_LEN(3), .TONE_CYCLES(TONE), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO), .END_CYCLES(ENDC)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .speedup(speedup),
    .btn_held(btn_held), .rand_val(rand_val), .rand_step(b_rand_step),
    .color(b_color), .color_en(b_color_en), .lose_tone(b_lose_tone),
    .win_flag(b_win_flag), .score(b_score), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; speedup = 1'b0; btn_held = '0; rand_val = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic start_game(input logic [1:0] rv);
    rand_val = rv;
    start = 1'b1;
    tick();
    check_eq("start_step", a_rand_step, 1);
    check_eq("start_busy", a_busy, 1);
    start = 1'b0;
    tick();
    check_eq("start_step_clr", a_rand_step, 0);
  endtask

  task automatic play_tones(input int n, input int tlen);
    int len;
    logic [1:0] col;
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < 40 && !a_color_en; w++) tick();
      check_eq("tone_on", a_color_en, 1);
      rand_val = 2'(k + 1);
      col = a_color;
      len = 0;
      while (a_color_en && len < 40) begin
        if (a_color !== col) col = 2'bxx;
        len++;
        tick();
      end
      check_eq($sformatf("tone%0d_col", k), col, exp_seq[k]);
      check_eq($sformatf("tone%0d_len", k), len, tlen);
    end
    repeat (GAP) tick();
  endtask

  task automatic press(input logic [1:0] b);
    btn_held = 4'b0001 << b;
    tick();
    check_eq("press_en", a_color_en, 1);
    check_eq("press_col", a_color, b);
    tick(); tick();
    btn_held = '0;
    tick();
  endtask

  task automatic play_round(input int r, input int tlen, input logic [1:0] next_rv);
    play_tones(r, tlen);
    for (int k = 0; k < r; k++) begin
      if (k == r - 1) rand_val = next_rv;
      press(exp_seq[k]);
    end
    check_eq("round_step", a_rand_step, 1);
    check_eq("round_score", a_score, r);
    tick();
    check_eq("round_step_clr", a_rand_step, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic dark;

    // Reset state, first round, then a wrong button in round 2.
    do_reset();
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_color_en", a_color_en, 0);
    check_eq("rst_color", a_color, 0);
    check_eq("rst_lose", a_lose_tone, 0);
    check_eq("rst_win", a_win_flag, 0);
    check_eq("rst_score", a_score, 0);
    check_eq("rst_step", a_rand_step, 0);
    check_eq("rst_b", {b_rand_step, b_color, b_color_en, b_lose_tone, b_win_flag, b_score, b_busy}, 0);
    exp_seq[0] = 2'd2; exp_seq[1] = 2'd0;
    start_game(2'd2);
    play_round(1, TONE, 2'd0);
    play_tones(2, TONE);
    press(2'd2);
    press(2'd1);
    check_eq("wrong_lose", a_lose_tone, 1);
    n = 0;
    while (a_lose_tone && n < 20) begin n++; tick(); end
    check_eq("lose_len", n, ENDC);
    check_eq("lose_idle", a_busy, 0);
    check_eq("lose_score", a_score, 1);

    // Three correct rounds 1,3,0; the MAX_LEN=3 unit wins.
    do_reset();
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd3; exp_seq[2] = 2'd0;
    start_game(2'd1);
    play_round(1, TONE, 2'd3);
    play_round(2, TONE, 2'd0);
    play_tones(3, TONE);
    rand_val = 2'd2;
    press(2'd1); press(2'd3); press(2'd0);
    check_eq("a_ext_step", a_rand_step, 1);
    check_eq("a_score3", a_score, 3);
    check_eq("b_score3", b_score, 3);
    n = 0; dark = 1'b1;
    while (b_win_flag && n < 20) begin
      if (b_color_en) dark = 1'b0;
      n++; tick();
    end
    check_eq("win_len", n, ENDC);
    check_eq("win_dark", dark, 1);
    check_eq("win_idle", b_busy, 0);
    check_eq("win_score", b_score, 3);

    // Two buttons at once in WAIT_IN.
    do_reset();
    exp_seq[0] = 2'd3;
    start_game(2'd3);
    play_tones(1, TONE);
    btn_held = 4'b1001;
    tick();
    check_eq("multi_lose", a_lose_tone, 1);
    check_eq("multi_dark", a_color_en, 0);
    btn_held = '0;

    // No press: LOSE after exactly TMO cycles of WAIT_IN.
    do_reset();
    exp_seq[0] = 2'd0;
    start_game(2'd0);
    play_tones(1, TONE);
    n = 0;
    while (!a_lose_tone && n < 40) begin tick(); n++; end
    check_eq("timeout_cycles", n, TMO);

    // Speed-up: tone halves once score reaches 8.
    do_reset();
    speedup = 1'b1;
    for (int i = 0; i < 16; i++) exp_seq[i] = 2'((i * 3 + 1) % 4);
    start_game(exp_seq[0]);
    for (int r = 1; r <= 8; r++) play_round(r, TONE, exp_seq[r]);
    play_tones(9, TONE / 2);

    // Asynchronous reset mid-PLAY_ON, and reset overriding start.
    do_reset();
    exp_seq[0] = 2'd2;
    start_game(2'd2);
    tick();
    check_eq("pre_rst_en", a_color_en, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", a_busy, 0);
    check_eq("arst_en", a_color_en, 0);
    check_eq("arst_color", a_color, 0);
    start = 1'b1;
    tick(); tick();
    check_eq("rst_vs_start", a_busy, 0);
    start = 1'b0;
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
